fft64_reorder: RTL and testbench
================================

Name: fft64_reorder

Overview:
- Output-side reader for the fft64 core: accepts the 64-point FFT result stream, which arrives in bit-reversed bin order, and re-emits it in natural bin order (bin 0..63).
- Ping-pong buffer of 2 banks x 64 complex words; one bank fills while the other drains, so back-to-back frames stream without stalls.
- Sits between the fft64 output and downstream demapping/carrier-extraction logic.

Parameters:
- W, 11, width of each real/imag sample (two's complement).
- N, 64, points per frame (power of 2).
- LOGN, 6, log2(N).

Ports:
- CLK  input  1  clock, all logic on rising edge
- RST  input  1  synchronous reset, active-high
- valid_b  input  1  input sample qualifier (FFT output valid)
- br  input  W  input real part, bit-reversed bin order
- bi  input  W  input imag part, bit-reversed bin order
- valid_c  output  1  output sample qualifier
- cr  output  W  output real part, natural order
- ci  output  W  output imag part, natural order
- idx  output  LOGN  bin index of the current output sample
- sof  output  1  high with bin 0 of each output frame
- eof  output  1  high with bin N-1 of each output frame

Behaviour:
- Reset (RST=1 at an edge): valid_c=0, cr=0, ci=0, idx=0, sof=0, eof=0.
  - Write counter, write-bank select, read counter and both bank-full flags clear to 0.
  - Buffer contents need not be cleared.
  - A reset mid-frame discards the partial write frame and any frame being drained; output goes quiet on the next cycle.
- Write side:
  - On each cycle with valid_b=1, store {br,bi} at address wcnt of the write bank, then increment wcnt (mod N).
  - valid_b=0 holds wcnt; gaps of any length are allowed.
  - When wcnt wraps N-1 -> 0, mark that bank full and toggle the write bank.
- Read side, states IDLE / DRAIN:
  - IDLE -> DRAIN on the cycle after a bank becomes full; rcnt=0.
  - In DRAIN, read address = bitrev_LOGN(rcnt) in the full bank; rcnt increments every cycle with no stall.
  - At rcnt=N-1: clear that bank's full flag. Then go to DRAIN of the other bank if it is already full, else IDLE.
- Output timing:
  - Read data is registered. If the last input word of a frame is accepted at edge t, bin k is presented with valid_c=1 after edge t+2+k (fixed latency of 2 cycles to bin 0).
  - idx=k for that sample; sof=1 at k=0; eof=1 at k=N-1.
  - valid_c=0 whenever no frame is draining; cr/ci hold their last values when valid_c=0.
- Continuous input (valid_b=1 every cycle) yields continuous output: valid_c stays high across the frame boundary, and sof directly follows eof.
- Overflow cannot occur: a fill takes at least N cycles and a drain takes exactly N. No back-pressure port.
- The bank being drained is never written. The write toggle and the read bank are independent pointers.
- Simultaneous events:
  - Completing a write frame in the same cycle as the drain's final read: the new bank is taken next cycle with no gap.
  - valid_b during reset is ignored.
- Pure reordering: no arithmetic, no width change, values pass bit-exact.

Test Plan:
- Index ramp: one frame, continuous valid_b, br=arrival count n (0..63), bi=-n. First valid_c 2 cycles after the 64th input. Output k gives cr=bitrev6(k): k=0->0, k=1->32, k=2->16, k=3->48, k=63->63; ci=-cr; sof at k=0, eof at k=63.
- Back-to-back: three ramp frames with continuous valid_b (frame f adds 100*f to br). Output 192 consecutive valid_c cycles. Frame 1 bin 1 gives cr=132. sof/eof each pulse 3 times.
- Gapped input: valid_b toggled 1,0,1,0 across one frame. Output is identical to the ramp case, with bin 0 exactly 2 cycles after the last accepted word.
- Signed extremes: arrival n=0 br=-1024, bi=1023; n=32 br=1023, bi=-1024. Output k=0 gives -1024/1023; k=1 gives 1023/-1024, bit-exact.
- Reset mid-operation: assert RST after 40 inputs of frame 0 and again during the drain of a full frame. valid_c=0 the cycle after reset. A following clean frame reorders correctly with bin 0 at cr=0.
- Idle: valid_b=0 for 200 cycles after reset -> valid_c, sof, eof stay 0; cr=ci=0.

Source files
------------

// File: rtl/fft64_reorder.sv
// fft64_reorder
// Output-side reader for the fft64 core. FFT results arrive in bit-reversed
// bin order; this block buffers each 64-point frame in one bank of a ping-pong
// memory and re-emits it in natural bin order from the other bank.
//
// Timing: when the last word of a frame is accepted at edge t, the frame's
// full flag is visible during the following cycle, the reader enters DRAIN at
// edge t+1, and bin k leaves the output register at edge t+2+k.
// A drain that ends while the other bank is already full rolls straight into
// that bank, so continuous input gives continuous output.

module fft64_reorder #(
    parameter int W    = 11,  // real/imag sample width (two's complement)
    parameter int N    = 64,  // points per frame (power of 2)
    parameter int LOGN = 6    // log2(N)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            valid_b,
    input  logic [W-1:0]    br,
    input  logic [W-1:0]    bi,
    output logic            valid_c,
    output logic [W-1:0]    cr,
    output logic [W-1:0]    ci,
    output logic [LOGN-1:0] idx,
    output logic            sof,
    output logic            eof
);

    // Reader states.
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    // Address of the last bin in a frame.
    localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

    // Mirror the LOGN address bits: natural bin k lives at address bitrev(k).
    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        r = '0;
        for (int b = 0; b < LOGN; b++) begin
            r[b] = a[LOGN-1-b];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Storage: two banks of N complex words, addressed as {bank, addr}.
    // ------------------------------------------------------------------
    logic [2*W-1:0] r_mem [0:2*N-1];

    // Write side
    logic [LOGN-1:0] r_wcnt;
    logic            r_wbank;
    logic            w_wr_en;
    logic            w_wrap;

    // Bank-full flags, one per bank
    logic [1:0]      r_full;

    // Read side
    logic [0:0]      r_state;
    logic            r_rbank;
    logic [LOGN-1:0] r_rcnt;
    logic [0:0]      w_state_nx;
    logic            w_rbank_nx;
    logic [LOGN-1:0] w_rcnt_nx;
    logic            w_rd_done;
    logic [LOGN:0]   w_raddr;

    // Output registers
    logic            r_valid_c;
    logic [W-1:0]    r_cr;
    logic [W-1:0]    r_ci;
    logic [LOGN-1:0] r_idx;
    logic            r_sof;
    logic            r_eof;

    // Words presented while reset is asserted are ignored.
    assign w_wr_en   = valid_b & ~RST;
    assign w_wrap    = w_wr_en && (r_wcnt == LAST);
    assign w_rd_done = (r_state == S_DRAIN) && (r_rcnt == LAST);
    assign w_raddr   = {r_rbank, bitrev(r_rcnt)};

    // Store each accepted input word at the current write address.
    // NOTE: the buffer has no reset; every location is written before the
    // reader can reach it, and leaving it out keeps the array mappable to RAM.
    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[{r_wbank, r_wcnt}] <= {br, bi};
        end
    end

    // Advance the write address on each accepted word; flip bank on wrap.
    // NOTE: all state registers use non-blocking assignment so every block
    // sees the pre-edge values and simulation matches the synthesised flops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wcnt  <= '0;
            r_wbank <= 1'b0;
        end else if (valid_b) begin
            r_wcnt <= r_wcnt + 1'b1;
            if (r_wcnt == LAST) begin
                r_wbank <= ~r_wbank;
            end
        end
    end

    // Mark a bank full when its last word lands; release it after its last read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_full <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_wrap && (r_wbank == 1'(b))) begin
                    r_full[b] <= 1'b1;
                end else if (w_rd_done && (r_rbank == 1'(b))) begin
                    r_full[b] <= 1'b0;
                end
            end
        end
    end

    // Reader next-state: start on any full bank, chain into the other bank
    // at the end of a drain if it has filled in the meantime.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nx = r_state;
        w_rbank_nx = r_rbank;
        w_rcnt_nx  = r_rcnt;
        case (r_state)
            S_IDLE: begin
                if (|r_full) begin
                    w_state_nx = S_DRAIN;
                    // With both banks full the write pointer sits on the
                    // older one; otherwise the full bank is the one just left.
                    w_rbank_nx = r_full[r_wbank] ? r_wbank : ~r_wbank;
                    w_rcnt_nx  = '0;
                end
            end
            S_DRAIN: begin
                w_rcnt_nx = r_rcnt + 1'b1;
                if (r_rcnt == LAST) begin
                    if (r_full[~r_rbank]) begin
                        w_rbank_nx = ~r_rbank;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Reader state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_rbank <= 1'b0;
            r_rcnt  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_rbank <= w_rbank_nx;
            r_rcnt  <= w_rcnt_nx;
        end
    end

    // Register the read word and its frame markers; data holds when idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid_c <= 1'b0;
            r_cr      <= '0;
            r_ci      <= '0;
            r_idx     <= '0;
            r_sof     <= 1'b0;
            r_eof     <= 1'b0;
        end else if (r_state == S_DRAIN) begin
            r_valid_c    <= 1'b1;
            {r_cr, r_ci} <= r_mem[w_raddr];
            r_idx        <= r_rcnt;
            r_sof        <= (r_rcnt == '0);
            r_eof        <= (r_rcnt == LAST);
        end else begin
            r_valid_c <= 1'b0;
            r_sof     <= 1'b0;
            r_eof     <= 1'b0;
        end
    end

    assign valid_c = r_valid_c;
    assign cr      = r_cr;
    assign ci      = r_ci;
    assign idx     = r_idx;
    assign sof     = r_sof;
    assign eof     = r_eof;

endmodule

// File: tb/tb_fft64_reorder.sv
// tb_fft64_reorder
// Drives frames into fft64_reorder and compares every output sample with a
// reference schedule built from the accepted input words: frame f completing
// at edge e has bin k (value = arrival bitrev(k)) at edge start+k, where
// start = max(e+2, end of previous frame + 1).

module tb_fft64_reorder;

    localparam int W    = 11;
    localparam int N    = 64;
    localparam int LOGN = 6;

    logic            CLK;
    logic            RST;
    logic            valid_b;
    logic [W-1:0]    br;
    logic [W-1:0]    bi;
    logic            valid_c;
    logic [W-1:0]    cr;
    logic [W-1:0]    ci;
    logic [LOGN-1:0] idx;
    logic            sof;
    logic            eof;

    typedef struct packed {
        logic [31:0]     e;
        logic [W-1:0]    r;
        logic [W-1:0]    i;
        logic [LOGN-1:0] idx;
        logic            sof;
        logic            eof;
    } smp_t;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] acc_r[$];
    logic [W-1:0] acc_i[$];
    int           done_e[$];
    smp_t         obs_q[$];
    smp_t         exp_q[$];

    fft64_reorder #(.W(W), .N(N), .LOGN(LOGN)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .valid_b (valid_b),
        .br      (br),
        .bi      (bi),
        .valid_c (valid_c),
        .cr      (cr),
        .ci      (ci),
        .idx     (idx),
        .sof     (sof),
        .eof     (eof)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Edge counter and input capture (inputs change on negedges only).
    always @(posedge CLK) begin
        cyc = cyc + 1;
        if (RST) begin
            acc_r.delete();
            acc_i.delete();
            done_e.delete();
        end else if (valid_b) begin
            acc_r.push_back(br);
            acc_i.push_back(bi);
            if (acc_r.size() % N == 0) done_e.push_back(cyc);
        end
    end

    // Output capture, sampled half a cycle after the active edge.
    always @(negedge CLK) begin
        if (valid_c === 1'b1) obs_q.push_back({32'(cyc), cr, ci, idx, sof, eof});
    end

    function automatic int brev6(input int k);
        int r = 0;
        for (int b = 0; b < LOGN; b++) r = r * 2 + ((k >> b) & 1);
        return r;
    endfunction

    function automatic string fmt(input smp_t s);
        return $sformatf("edge=%0d cr=%0d ci=%0d idx=%0d sof=%0b eof=%0b",
                         s.e, $signed(s.r), $signed(s.i), s.idx, s.sof, s.eof);
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] r, input logic [W-1:0] i);
        @(negedge CLK);
        valid_b = v;
        br      = r;
        bi      = i;
    endtask

    task automatic clear_model();
        acc_r.delete();
        acc_i.delete();
        done_e.delete();
        obs_q.delete();
        exp_q.delete();
    endtask

    // Build the expected natural-order output schedule from captured frames.
    task automatic build_expected();
        int   last_end;
        int   start;
        smp_t s;
        last_end = -1000;
        exp_q.delete();
        for (int f = 0; f < done_e.size(); f++) begin
            start = (done_e[f] + 2 > last_end + 1) ? done_e[f] + 2 : last_end + 1;
            for (int k = 0; k < N; k++) begin
                s.e   = 32'(start + k);
                s.r   = acc_r[N * f + brev6(k)];
                s.i   = acc_i[N * f + brev6(k)];
                s.idx = LOGN'(k);
                s.sof = (k == 0);
                s.eof = (k == N - 1);
                exp_q.push_back(s);
            end
            last_end = start + N - 1;
        end
    endtask

    // Wait until the last expected sample is past (always a finite target).
    task automatic drain_wait();
        int target;
        build_expected();
        target = (exp_q.size() > 0) ? int'(exp_q[exp_q.size()-1].e) + 3 : cyc + 3;
        while (cyc < target) @(negedge CLK);
    endtask

    task automatic do_reset(input int n);
        @(negedge CLK);
        RST     = 1'b1;
        valid_b = 1'b1;
        br      = W'($urandom);
        bi      = W'($urandom);
        repeat (n) @(negedge CLK);
        RST     = 1'b0;
        valid_b = 1'b0;
        clear_model();
    endtask

    task automatic test_reset();
        logic [2*W+LOGN+2:0] got;
        do_reset(3);
        got = {valid_c, cr, ci, idx, sof, eof};
        n_checks++;
        if (got !== '0) $display("FAIL reset_state got %h want 0", got);
        else n_pass++;
    endtask

    task automatic test_idle();
        logic [2*W+LOGN+2:0] got;
        for (int c = 0; c < 200; c++) begin
            drive(1'b0, W'($urandom), W'($urandom));
            got = {valid_c, cr, ci, idx, sof, eof};
            n_checks++;
            if (got !== '0) $display("FAIL idle_cycle%0d got %h want 0", c, got);
            else n_pass++;
        end
    endtask

    task automatic test_ramp();
        smp_t got;
        clear_model();
        for (int n = 0; n < N; n++) drive(1'b1, W'(n), W'(-n));
        drive(1'b0, '0, '0);
        drain_wait();
        n_checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL ramp_count got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int j = 0; j < exp_q.size(); j++) begin
            got = (j < obs_q.size()) ? obs_q[j] : '0;
            n_checks++;
            if (got !== exp_q[j]) $display("FAIL ramp_bin%0d got %s want %s", j, fmt(got), fmt(exp_q[j]));
            else n_pass++;
        end
        got = (obs_q.size() > 1) ? obs_q[1] : '0;
        n_checks++;
        if (got.r !== W'(32)) $display("FAIL ramp_k1 got cr=%0d want 32", got.r);
        else n_pass++;
        got = (obs_q.size() > 3) ? obs_q[3] : '0;
        n_checks++;
        if (got.r !== W'(48)) $display("FAIL ramp_k3 got cr=%0d want 48", got.r);
        else n_pass++;
        got = (obs_q.size() > 2) ? obs_q[2] : '0;
        n_checks++;
        if (got.i !== W'(-16)) $display("FAIL ramp_k2_ci got ci=%0d want -16", $signed(got.i));
        else n_pass++;
        got = (obs_q.size() > 63) ? obs_q[63] : '0;
        n_checks++;
        if (got.r !== W'(63) || got.eof !== 1'b1)
            $display("FAIL ramp_k63 got cr=%0d eof=%0b want 63/1", got.r, got.eof);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        smp_t got;
        int   n_sof;
        int   n_eof;
        clear_model();
        for (int f = 0; f < 3; f++)
            for (int n = 0; n < N; n++) drive(1'b1, W'(n + 100 * f), W'(-n));
        drive(1'b0, '0, '0);
        drain_wait();
        n_checks++;
        if (obs_q.size() !== 192) $display("FAIL b2b_count got %0d want 192", obs_q.size());
        else n_pass++;
        for (int j = 0; j < exp_q.size(); j++) begin
            got = (j < obs_q.size()) ? obs_q[j] : '0;
            n_checks++;
            if (got !== exp_q[j]) $display("FAIL b2b_bin%0d got %s want %s", j, fmt(got), fmt(exp_q[j]));
            else n_pass++;
        end
        n_checks++;
        if (obs_q.size() != 192 || obs_q[191].e - obs_q[0].e != 191)
            $display("FAIL b2b_continuous got size=%0d (span not 191 or short)", obs_q.size());
        else n_pass++;
        got = (obs_q.size() > 65) ? obs_q[65] : '0;
        n_checks++;
        if (got.r !== W'(132)) $display("FAIL b2b_f1k1 got cr=%0d want 132", got.r);
        else n_pass++;
        n_sof = 0;
        n_eof = 0;
        foreach (obs_q[j]) begin
            n_sof += int'(obs_q[j].sof);
            n_eof += int'(obs_q[j].eof);
        end
        n_checks++;
        if (n_sof != 3 || n_eof != 3) $display("FAIL b2b_markers got sof=%0d eof=%0d want 3/3", n_sof, n_eof);
        else n_pass++;
    endtask

    task automatic test_gapped();
        smp_t got;
        clear_model();
        for (int n = 0; n < N; n++) begin
            drive(1'b1, W'(n), W'(-n));
            drive(1'b0, W'($urandom), W'($urandom));
        end
        drain_wait();
        n_checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL gap_count got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int j = 0; j < exp_q.size(); j++) begin
            got = (j < obs_q.size()) ? obs_q[j] : '0;
            n_checks++;
            if (got !== exp_q[j]) $display("FAIL gap_bin%0d got %s want %s", j, fmt(got), fmt(exp_q[j]));
            else n_pass++;
        end
    endtask

    task automatic test_extremes();
        smp_t got;
        clear_model();
        for (int n = 0; n < N; n++) begin
            if (n == 0)       drive(1'b1, 11'h400, 11'h3FF);
            else if (n == 32) drive(1'b1, 11'h3FF, 11'h400);
            else              drive(1'b1, W'($urandom), W'($urandom));
        end
        drive(1'b0, '0, '0);
        drain_wait();
        for (int j = 0; j < exp_q.size(); j++) begin
            got = (j < obs_q.size()) ? obs_q[j] : '0;
            n_checks++;
            if (got !== exp_q[j]) $display("FAIL ext_bin%0d got %s want %s", j, fmt(got), fmt(exp_q[j]));
            else n_pass++;
        end
        got = (obs_q.size() > 0) ? obs_q[0] : '0;
        n_checks++;
        if (got.r !== 11'h400 || got.i !== 11'h3FF)
            $display("FAIL ext_k0 got %0d/%0d want -1024/1023", $signed(got.r), $signed(got.i));
        else n_pass++;
        got = (obs_q.size() > 1) ? obs_q[1] : '0;
        n_checks++;
        if (got.r !== 11'h3FF || got.i !== 11'h400)
            $display("FAIL ext_k1 got %0d/%0d want 1023/-1024", $signed(got.r), $signed(got.i));
        else n_pass++;
    endtask

    task automatic test_random();
        smp_t got;
        int   gap;
        clear_model();
        for (int f = 0; f < 6; f++) begin
            for (int n = 0; n < N; n++) begin
                while ($urandom_range(0, 9) < 3) drive(1'b0, W'($urandom), W'($urandom));
                drive(1'b1, W'($urandom), W'($urandom));
            end
            gap = (f % 2 == 0) ? 0 : int'($urandom_range(0, 70));
            repeat (gap) drive(1'b0, W'($urandom), W'($urandom));
        end
        drive(1'b0, '0, '0);
        drain_wait();
        n_checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int j = 0; j < exp_q.size(); j++) begin
            got = (j < obs_q.size()) ? obs_q[j] : '0;
            n_checks++;
            if (got !== exp_q[j]) $display("FAIL rand_bin%0d got %s want %s", j, fmt(got), fmt(exp_q[j]));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        smp_t got;
        int   guard;
        // Reset part-way through filling frame 0, with valid_b held high.
        clear_model();
        for (int n = 0; n < 40; n++) drive(1'b1, W'(n), W'(-n));
        do_reset(2);
        n_checks++;
        if (valid_c !== 1'b0) $display("FAIL rst_fill_quiet got valid_c=%b want 0", valid_c);
        else n_pass++;
        // Reset in the middle of draining a full frame.
        for (int n = 0; n < N; n++) drive(1'b1, W'($urandom), W'($urandom));
        drive(1'b0, '0, '0);
        guard = 0;
        while ((done_e.size() == 0 || cyc < done_e[0] + 20) && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        n_checks++;
        if (valid_c !== 1'b1) $display("FAIL rst_drain_active got valid_c=%b want 1", valid_c);
        else n_pass++;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (valid_c !== 1'b0 || sof !== 1'b0 || eof !== 1'b0)
            $display("FAIL rst_drain_quiet got valid_c=%b sof=%b eof=%b want 0", valid_c, sof, eof);
        else n_pass++;
        RST = 1'b0;
        clear_model();
        repeat (80) drive(1'b0, W'($urandom), W'($urandom));
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL rst_discard got %0d samples want 0", obs_q.size());
        else n_pass++;
        // A clean frame afterwards reorders correctly.
        clear_model();
        for (int n = 0; n < N; n++) drive(1'b1, W'(n), W'(-n));
        drive(1'b0, '0, '0);
        drain_wait();
        n_checks++;
        if (obs_q.size() !== exp_q.size() || exp_q.size() != N)
            $display("FAIL rst_clean_count got %0d want %0d", obs_q.size(), N);
        else n_pass++;
        for (int j = 0; j < exp_q.size(); j++) begin
            got = (j < obs_q.size()) ? obs_q[j] : '0;
            n_checks++;
            if (got !== exp_q[j]) $display("FAIL rst_clean_bin%0d got %s want %s", j, fmt(got), fmt(exp_q[j]));
            else n_pass++;
        end
        got = (obs_q.size() > 0) ? obs_q[0] : '1;
        n_checks++;
        if (got.r !== '0 || got.sof !== 1'b1)
            $display("FAIL rst_clean_k0 got cr=%0d sof=%0b want 0/1", got.r, got.sof);
        else n_pass++;
    endtask

    initial begin
        RST     = 1'b1;
        valid_b = 1'b0;
        br      = '0;
        bi      = '0;
        test_reset();
        test_idle();
        test_ramp();
        test_back_to_back();
        test_gapped();
        test_extremes();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
